// File: rtl/bath_mode_ctrl_if.sv
// bath_mode_ctrl_if: panel-side signal bundle between the bath mode controller and its surroundings.
//   stay               standby-complete flag from the display stage
//   mode_btn/start_btn raw asynchronous pushbuttons, active-high
//   seg_data           displayed digit (always 0..9)
//   normal             run indicator for the downstream tube-enable term
//   heater/fan/light   load enables
//   buzz               completion buzzer
// master drives stay and the buttons; slave is the controller.
interface bath_mode_ctrl_if;
   logic       stay;
   logic       mode_btn;
   logic       start_btn;
   logic [3:0] seg_data;
   logic       normal;
   logic       heater;
   logic       fan;
   logic       light;
   logic       buzz;
   modport master (output stay, mode_btn, start_btn,
                   input  seg_data, normal, heater, fan, light, buzz);
   modport slave  (input  stay, mode_btn, start_btn,
                   output seg_data, normal, heater, fan, light, buzz);
endinterface

// File: rtl/bath_mode_ctrl.sv
// bath_mode_ctrl: debounced two-button mode selector and per-mode countdown timer for the bath heater panel.
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    bath_mode_ctrl_if.slave: stay and raw buttons in; seg_data, normal, loads and buzz out (all registered)
module bath_mode_ctrl #(
   parameter int CLK_HZ   = 50_000_000,
   parameter int DEB_CYC  = 1_000_000,
   parameter int UNIT_SEC = 60,
   parameter int DUR_1    = 5,
   parameter int DUR_2    = 3,
   parameter int DUR_3    = 9,
   parameter int DUR_4    = 2,
   parameter int DONE_SEC = 3
) (
   input logic             clk,
   input logic             rst_n,
   bath_mode_ctrl_if.slave bus
);
   localparam int PW = $clog2(CLK_HZ + 1);
   localparam int DW = $clog2(DEB_CYC + 1);
   localparam int SW = $clog2(UNIT_SEC + 1);
   localparam int CW = $clog2(DONE_SEC + 1);

   typedef enum logic [2:0] {S_OFF, S_SEL, S_RUN, S_PAUSE, S_DONE} state_t;

   state_t          state, nstate;
   logic [PW-1:0]   pre, pre_n;
   logic [SW-1:0]   sec, sec_n;
   logic [CW-1:0]   dcn, dcn_n;
   logic [3:0]      rem, rem_n, seg_n;
   logic [2:0]      mode, mode_n;
   logic            normal_n, heater_n, fan_n, light_n, buzz_n, tick, run_n;
   logic [1:0]      raw, s1, s2, deb, press;
   logic [DW-1:0]   dcnt [2];

   function automatic logic [3:0] dur(input logic [2:0] m);
      return m == 3'd1 ? 4'(DUR_1) : m == 3'd2 ? 4'(DUR_2) : m == 3'd3 ? 4'(DUR_3) : 4'(DUR_4);
   endfunction

   // bit 0 = mode button, bit 1 = start button
   assign raw = {bus.start_btn, bus.mode_btn};

   // press pulses on the cycle the debounced level rises; releases only update the level
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1      <= '0;
         s2      <= '0;
         deb     <= '0;
         press   <= '0;
         dcnt[0] <= '0;
         dcnt[1] <= '0;
      end else begin
         s1 <= raw;
         s2 <= s1;
         for (int i = 0; i < 2; i++) begin
            press[i] <= 1'b0;
            if (s2[i] == deb[i])
               dcnt[i] <= '0;
            else if (dcnt[i] == DW'(DEB_CYC - 1)) begin
               deb[i]   <= s2[i];
               dcnt[i]  <= '0;
               press[i] <= s2[i];
            end else
               dcnt[i] <= dcnt[i] + 1'b1;
         end
      end
   end

   assign tick = (state == S_RUN || state == S_DONE) && pre == PW'(CLK_HZ - 1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= S_OFF;
         pre          <= '0;
         sec          <= '0;
         dcn          <= '0;
         rem          <= '0;
         mode         <= 3'd1;
         bus.seg_data <= '0;
         bus.normal   <= 1'b0;
         bus.heater   <= 1'b0;
         bus.fan      <= 1'b0;
         bus.light    <= 1'b0;
         bus.buzz     <= 1'b0;
      end else begin
         state        <= nstate;
         pre          <= pre_n;
         sec          <= sec_n;
         dcn          <= dcn_n;
         rem          <= rem_n;
         mode         <= mode_n;
         bus.seg_data <= seg_n;
         bus.normal   <= normal_n;
         bus.heater   <= heater_n;
         bus.fan      <= fan_n;
         bus.light    <= light_n;
         bus.buzz     <= buzz_n;
      end
   end

   // counters keep advancing in a RUN cycle that also sees a start press, so the
   // accumulated RUN time is exact; a finishing tick wins over a pause request
   always_comb begin
      nstate = state;
      pre_n  = pre;
      sec_n  = sec;
      dcn_n  = dcn;
      rem_n  = rem;
      mode_n = mode;
      if (state == S_RUN || state == S_DONE)
         pre_n = tick ? '0 : pre + 1'b1;
      case (state)
         S_OFF: begin
            mode_n = 3'd1;
            if (bus.stay)
               nstate = S_SEL;
         end
         S_SEL: begin
            if (press[1]) begin
               nstate = S_RUN;
               rem_n  = dur(mode);
               sec_n  = '0;
               pre_n  = '0;
            end else if (press[0])
               mode_n = mode == 3'd4 ? 3'd1 : mode + 3'd1;
         end
         S_RUN: begin
            if (tick)
               sec_n = sec == SW'(UNIT_SEC - 1) ? '0 : sec + 1'b1;
            if (tick && sec == SW'(UNIT_SEC - 1))
               rem_n = rem - 4'd1;
            if (tick && sec == SW'(UNIT_SEC - 1) && rem == 4'd1) begin
               nstate = S_DONE;
               dcn_n  = '0;
            end else if (press[1])
               nstate = S_PAUSE;
         end
         S_PAUSE: begin
            if (press[1])
               nstate = S_RUN;
            else if (press[0])
               nstate = S_SEL;
         end
         S_DONE: begin
            if (press[1] || press[0])
               nstate = S_SEL;
            else if (tick && dcn == CW'(DONE_SEC - 1))
               nstate = S_SEL;
            else if (tick)
               dcn_n = dcn + 1'b1;
         end
         default: nstate = S_OFF;
      endcase
      if (!bus.stay)
         nstate = S_OFF;
   end

   // outputs are computed from the next-state values so they change on the entering edge
   always_comb begin
      run_n    = nstate == S_RUN;
      seg_n    = nstate == S_SEL ? {1'b0, mode_n} : (nstate == S_RUN || nstate == S_PAUSE) ? rem_n : 4'd0;
      normal_n = run_n;
      heater_n = run_n && (mode_n == 3'd1 || mode_n == 3'd4);
      fan_n    = run_n && mode_n != 3'd3;
      light_n  = run_n && mode_n >= 3'd3;
      buzz_n   = nstate == S_DONE;
   end
endmodule
